cam_line_frame_monitor: RTL
===========================

// Module: cam_line_frame_monitor
// PURPOSE
//  Avalon-MM slave that sequences measurement of camera line/frame timing: counts pixels per
//  line (H count) and lines per frame (V count) from sync strobes, latches stable per-frame
//  snapshots for Nios readback and raises a frame-done interrupt. Sits between the camera
//  capture front end and the Nios bus; replaces free-running H/V PIO sampling.
// PARAMETERS
//  CNT_W    16  width of H and V counters and snapshot registers (max 16)
//  FCNT_W   32  width of completed-frame counter (max 32)
// PORTS
//  clk         in   1       system clock; all inputs synchronous to it
//  reset_n     in   1       asynchronous, active-low reset
//  cam_fval    in   1       frame valid, high during frame
//  cam_lval    in   1       line valid, high during line
//  cam_pix_en  in   1       pixel strobe; counted only while cam_lval high
//  chipselect  in   1       slave select
//  address     in   3       register index
//  write       in   1       write strobe (qualified by chipselect)
//  writedata   in   32      write data
//  readdata    out  32      registered read mux, 1-cycle latency, always updated
//  irq         out  1       level interrupt = CTRL.irq_en & STATUS.frame_done
// BEHAVIOUR
//  Reset: readdata=0, irq=0, all registers/counters 0, FSM=IDLE.
//  Registers (unused bits read 0; writes to RO ignored):
//   0 CTRL RW  b0 enable, b1 single_shot, b2 irq_en
//   1 STAT     b0 busy (RO, FSM!=IDLE), b1 frame_done (W1C), b2 overflow (W1C)
//   2 H_LAST RO pixels in last completed line of last completed frame
//   3 V_LAST RO lines in last completed frame
//   4 FRAMES RO completed frames, wraps 2^FCNT_W-1 -> 0; write any value clears to 0
//   5 LIVE   RO {v_cur[15:0], h_cur[15:0]}, zero-extended when CNT_W<16
//  Edge detect: fval/lval registered once; rise = in & ~q, fall = ~in & q.
//  FSM: IDLE -> WAIT_SOF when enable=1.
//   WAIT_SOF: clear h_cur, v_cur; on fval rise -> ACTIVE (ignores frame in progress at enable).
//   ACTIVE: h_cur++ on pix_en & lval; on lval fall: v_cur++ and h_line<=h_cur (frame-local
//     shadow), h_cur<=0. On fval fall: V_LAST<=v_cur (+1 if lval fall same cycle),
//     H_LAST<=h_line (or h_cur if lval fall same cycle), FRAMES++, frame_done<=1;
//     single_shot ? (enable<=0, -> IDLE) : -> WAIT_SOF.
//  Saturation: h_cur/v_cur hold at 2^CNT_W-1, overflow<=1; snapshot takes saturated value.
//  enable written 0 in any state -> IDLE next cycle; counters cleared; snapshots, FRAMES,
//   sticky bits kept. Writing enable=1 while already 1 has no effect.
//  Same-cycle W1C and hardware set of a sticky bit: set wins.
//  readdata <= (chipselect? mux(address) : 0) each clk; address 6,7 read 0.
//  Pix strobe on cycle of lval fall not counted (lval_q already low counts as line ended? no:
//   count uses raw lval, so strobe with lval=1 counts, lval=0 does not).
// STRUCTURE
//  Shared package cam_pkg: register address constants, CTRL/STAT bit indices,
//   FSM state enum {IDLE, WAIT_SOF, ACTIVE}.
//  One sub-module: cam_sync_edge (1-bit register + rise/fall outputs), instanced for fval, lval.
//  FSM, counters and register file in the top module.
// TESTING
//  1 Reset mid-frame (ACTIVE, h_cur=37) -> all regs 0, readdata 0, irq 0, busy 0 next cycle.
//  2 enable=1, irq_en=1; frame of 4 lines x 640 pix -> H_LAST=640, V_LAST=4, FRAMES=1,
//    frame_done=1, irq=1; W1C STAT=0x2 -> irq 0 next cycle.
//  3 enable asserted mid-frame -> partial frame ignored; next full 480x752 frame reports 480/752.
//  4 single_shot=1, two back-to-back frames -> only first counted, FRAMES=1, CTRL.enable=0.
//  5 CNT_W=8, line of 300 pix -> H_LAST=255, overflow=1; W1C in same cycle as new overflow -> stays 1.
//  6 lval and fval fall same cycle on 3rd line -> V_LAST=3, H_LAST=last-line pixel count.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera line/frame timing monitor: register map,
// control/status bit positions and sequencer states.
package cam_pkg;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_STAT   = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_H_LAST = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_V_LAST = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_FRAMES = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_LIVE   = 3'd5;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_SS     = 1;
   localparam int unsigned CTRL_IRQ_EN = 2;

   localparam int unsigned STAT_BUSY = 0;
   localparam int unsigned STAT_DONE = 1;
   localparam int unsigned STAT_OVF  = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      ACTIVE   = 2'd2
   } state_e;

endpackage

// File: rtl/cam_line_frame_monitor_if.sv
// Avalon-MM slave port bundle of the line/frame monitor, including its interrupt.
interface cam_line_frame_monitor_if;
   import cam_pkg::*;

   logic              chipselect;
   logic [ADDR_W-1:0] address;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              irq;

   modport slave  (input  chipselect, address, write, writedata,
                   output readdata, irq);
   modport master (output chipselect, address, write, writedata,
                   input  readdata, irq);
endinterface

// File: rtl/cam_sync_edge.sv
// One-stage register on a sync strobe with combinational rise/fall detect.
module cam_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic rise_c_o,
   output logic fall_c_o
);

   logic d_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) d_q <= 1'b0;
      else          d_q <= d_i;
   end

   assign rise_c_o = d_i & ~d_q;
   assign fall_c_o = ~d_i & d_q;

endmodule

// File: rtl/cam_line_frame_monitor.sv
// Camera H/V timing monitor: counts pixels per line and lines per frame, latches
// per-frame snapshots for bus readback and flags frame completion.
module cam_line_frame_monitor
   import cam_pkg::*;
#(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned FCNT_W = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cam_fval,
   input  logic                    cam_lval,
   input  logic                    cam_pix_en,
   cam_line_frame_monitor_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic fval_rise, fval_fall, lval_rise, lval_fall;

   cam_sync_edge u_fval_edge (
      .clk      (clk),
      .reset_n  (reset_n),
      .d_i      (cam_fval),
      .rise_c_o (fval_rise),
      .fall_c_o (fval_fall)
   );

   cam_sync_edge u_lval_edge (
      .clk      (clk),
      .reset_n  (reset_n),
      .d_i      (cam_lval),
      .rise_c_o (lval_rise),
      .fall_c_o (lval_fall)
   );

   state_e              state_q, state_d;
   logic                en_q, en_d, ss_q, ss_d, irq_en_q, irq_en_d;
   logic                done_q, done_d, ovf_q, ovf_d;
   logic [CNT_W-1:0]    h_cur_q, h_cur_d, v_cur_q, v_cur_d, h_line_q, h_line_d;
   logic [CNT_W-1:0]    h_last_q, h_last_d, v_last_q, v_last_d;
   logic [FCNT_W-1:0]   frames_q, frames_d;
   logic [DATA_W-1:0]   readdata_q, readdata_d;
   logic                irq_q, irq_d;

   logic wr, wr_ctrl, wr_stat, wr_frames, done_set, ovf_set;

   // Next-state: bus writes first, then the sequencer so hardware events take priority.
   always_comb begin
      state_d    = state_q;
      en_d       = en_q;
      ss_d       = ss_q;
      irq_en_d   = irq_en_q;
      done_d     = done_q;
      ovf_d      = ovf_q;
      h_cur_d    = h_cur_q;
      v_cur_d    = v_cur_q;
      h_line_d   = h_line_q;
      h_last_d   = h_last_q;
      v_last_d   = v_last_q;
      frames_d   = frames_q;
      readdata_d = '0;
      done_set   = 1'b0;
      ovf_set    = 1'b0;

      wr        = bus.chipselect & bus.write;
      wr_ctrl   = wr && (bus.address == ADDR_CTRL);
      wr_stat   = wr && (bus.address == ADDR_STAT);
      wr_frames = wr && (bus.address == ADDR_FRAMES);

      if (wr_ctrl) begin
         en_d     = bus.writedata[CTRL_EN];
         ss_d     = bus.writedata[CTRL_SS];
         irq_en_d = bus.writedata[CTRL_IRQ_EN];
      end
      if (wr_stat && bus.writedata[STAT_DONE]) done_d = 1'b0;
      if (wr_stat && bus.writedata[STAT_OVF])  ovf_d  = 1'b0;
      if (wr_frames) frames_d = '0;

      case (state_q)
         IDLE: begin
            h_cur_d  = '0;
            v_cur_d  = '0;
            h_line_d = '0;
            if (en_q) state_d = WAIT_SOF;
         end
         WAIT_SOF: begin
            h_cur_d  = '0;
            v_cur_d  = '0;
            h_line_d = '0;
            if (fval_rise) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (cam_pix_en && cam_lval) begin
               if (h_cur_q == CNT_MAX) ovf_set = 1'b1;
               else                    h_cur_d = h_cur_q + CNT_W'(1);
            end
            if (lval_fall) begin
               if (v_cur_q == CNT_MAX) ovf_set = 1'b1;
               else                    v_cur_d = v_cur_q + CNT_W'(1);
               h_line_d = h_cur_q;
               h_cur_d  = '0;
            end
            // End of frame: a line closing on the same edge is folded into the snapshot.
            if (fval_fall) begin
               v_last_d = v_cur_d;
               h_last_d = lval_fall ? h_cur_q : h_line_q;
               frames_d = frames_q + FCNT_W'(1);
               done_set = 1'b1;
               if (ss_q) begin
                  en_d    = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_SOF;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (wr_ctrl && !bus.writedata[CTRL_EN]) begin
         state_d  = IDLE;
         h_cur_d  = '0;
         v_cur_d  = '0;
         h_line_d = '0;
      end

      done_d = done_d | done_set;
      ovf_d  = ovf_d | ovf_set;
      irq_d  = irq_en_d & done_d;

      if (bus.chipselect) begin
         case (bus.address)
            ADDR_CTRL:   readdata_d = {29'd0, irq_en_q, ss_q, en_q};
            ADDR_STAT:   readdata_d = {29'd0, ovf_q, done_q, (state_q != IDLE)};
            ADDR_H_LAST: readdata_d = 32'(h_last_q);
            ADDR_V_LAST: readdata_d = 32'(v_last_q);
            ADDR_FRAMES: readdata_d = 32'(frames_q);
            ADDR_LIVE:   readdata_d = {16'(v_cur_q), 16'(h_cur_q)};
            default:     readdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         en_q       <= 1'b0;
         ss_q       <= 1'b0;
         irq_en_q   <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         h_cur_q    <= '0;
         v_cur_q    <= '0;
         h_line_q   <= '0;
         h_last_q   <= '0;
         v_last_q   <= '0;
         frames_q   <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         ss_q       <= ss_d;
         irq_en_q   <= irq_en_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         h_cur_q    <= h_cur_d;
         v_cur_q    <= v_cur_d;
         h_line_q   <= h_line_d;
         h_last_q   <= h_last_d;
         v_last_q   <= v_last_d;
         frames_q   <= frames_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign bus.irq      = irq_q;

   logic unused_edges;
   assign unused_edges = lval_rise;

endmodule
